fault_mem_multi: RTL and testbench
==================================

Name: fault_mem_multi

Overview:
Parametrised fault-injecting single-port memory model used as the device under test for the MBIST controller. It is the successor to the single-coupling-fault memory.
- Supports four run-time-selectable fault models: SAF0, SAF1, transition-up and inversion coupling.
- Victim address and bit are programmable, so the fault location is not a build-time constant.
- Adds an access enable, a read-valid strobe and a saturating fault-activation counter.
- Sits between the MBIST controller and the scoreboard, standing in for a real SRAM macro.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, address width
DEPTH, 2**ADDR_WIDTH, number of implemented words; must be >= 2 and <= 2**ADDR_WIDTH
CNT_WIDTH, 8, width of fault_cnt

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  access request this cycle
write_read  in  1  1 = write, 0 = read
address  in  ADDR_WIDTH  access address
wdata  in  DATA_WIDTH  write data
fault_en  in  1  0 = ideal memory
fault_type  in  2  0 SAF0, 1 SAF1, 2 TF_UP, 3 CFIN
fault_addr  in  ADDR_WIDTH  victim word address V
fault_bit  in  $clog2(DATA_WIDTH)  victim/aggressor bit index b
rdata  out  DATA_WIDTH  read data
rvalid  out  1  rdata valid strobe, one cycle per read
fault_cnt  out  CNT_WIDTH  number of fault activations, saturating

Behaviour:
- Reset (rst=1 at an edge):
  - rdata=0, rvalid=0, fault_cnt=0.
  - Stage registers cleared; any in-flight access is dropped and produces no write and no rvalid.
  - The memory array is not cleared.
- Pipeline, for a request sampled at edge N:
  - Edge N: en, write_read, address and wdata are captured into the stage registers.
  - Edge N+1: the write is executed, or the read data is registered.
  - Edge N+2: rdata is updated and rvalid=1 for exactly one cycle.
  - Read latency is 2 cycles. A new request is accepted every cycle.
  - Write at N followed by a read of the same address at N+1 returns the new data. No bypass logic is needed, because the write completes at N+1 and the read array access occurs at N+2.
- en=0: no access; rvalid=0 two cycles later; rdata holds its last value.
- Out-of-range address (>= DEPTH): the write is ignored; the read returns 0 with rvalid=1; no fault activation.
- Fault configuration ports:
  - Sampled at the execution edge (N+1).
  - Must be stable while accesses are in flight.
  - fault_en=0 means ideal memory.
- SAF0/SAF1:
  - On a write to V, stored bit b is forced to 0/1.
  - On a read of V, the returned bit b is also forced.
  - Activation = the forced value differs from the written value (write) or from the stored value (read).
- TF_UP:
  - On a write to V where stored bit b = 0 and wdata bit b = 1, bit b stays 0; all other bits are written normally.
  - Activation = the transition was blocked.
- CFIN:
  - Aggressor A = (V+1) mod DEPTH, with wrap-around.
  - On a write to A where old A bit b = 0 and new bit b = 1, A is written normally and V bit b is inverted on the same edge.
  - Activation = the inversion occurred.
  - A write to V itself is fault-free.
- fault_cnt:
  - +1 per activation, at most one activation per access.
  - Saturates at 2**CNT_WIDTH-1.
- Only one fault is active at a time; no fault affects addresses other than V (and A for CFIN).

Decomposition:
- Package fault_mem_pkg holds:
  - fault type localparams FT_SAF0=0, FT_SAF1=1, FT_TF_UP=2, FT_CFIN=3;
  - a function computing the aggressor address with wrap-around.
- Sub-module fault_mem_inject: purely combinational.
  - Inputs: op, address, wdata, old word at the address, old victim word, fault configuration.
  - Outputs: word to store, victim word to store plus its write enable, corrected read word, activation flag.
- The top level holds the stage registers, array, output registers and counter.

Test Plan:
All cases use DATA_WIDTH=8, ADDR_WIDTH=4.
1. fault_en=0; write 0xA5 to address 3, then read 3 -> rdata=0xA5 with rvalid pulse 2 cycles after the read request; fault_cnt=0.
2. SAF0, V=5, b=2:
   - write 0xFF to 5, read 5 -> 0xFB, fault_cnt=1;
   - write 0x00, read -> 0x00, fault_cnt stays 1.
3. TF_UP, V=7, b=0:
   - write 0x00, write 0x01, read -> 0x00, fault_cnt=1;
   - write 0x03, read -> 0x02, fault_cnt=2.
4. CFIN, V=15, b=5 (aggressor wraps to 0):
   - write 0x00 to 15, write 0x00 to 0, write 0x20 to 0;
   - read 15 -> 0x20, read 0 -> 0x20, fault_cnt=1;
   - repeat the 0x20 write to 0 -> no further inversion, fault_cnt=1.
5. Reset and out-of-range:
   - issue a read, assert rst on the next edge -> rvalid never pulses, rdata=0;
   - with DEPTH=12, write 0x55 to 13, read 13 -> 0x00 with rvalid=1.
6. Back-to-back write 0x3C then read of address 9 on consecutive cycles -> 0x3C; fault_cnt saturates at 255 with CNT_WIDTH=8 under repeated SAF1 activations.

Source files
------------

// File: rtl/fault_mem_pkg.sv
// Shared definitions for the fault-injecting memory model.
//   FT_*            : encodings of the run-time fault_type input
//   aggressor_addr  : coupling-fault aggressor address (victim + 1, wrapping at depth)
package fault_mem_pkg;

  localparam logic [1:0] FT_SAF0  = 2'd0;
  localparam logic [1:0] FT_SAF1  = 2'd1;
  localparam logic [1:0] FT_TF_UP = 2'd2;
  localparam logic [1:0] FT_CFIN  = 2'd3;

  function automatic logic [31:0] aggressor_addr(input logic [31:0] victim,
                                                 input logic [31:0] depth);
    return (victim + 32'd1 >= depth) ? 32'd0 : victim + 32'd1;
  endfunction

endpackage

// File: rtl/fault_mem_inject.sv
// Combinational fault injector for one memory access.
// Inputs : is_write, address, wdata, old_word (current contents at address),
//          old_victim (current contents at fault_addr), fault configuration.
// Outputs: store_word (word to write at address), victim_word/victim_we
//          (coupling-fault update of the victim), read_word (read data after
//          fault correction), activated (this access triggered the fault).
// Range checks of address/fault_addr are left to the caller.
module fault_mem_inject #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                          is_write,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH-1:0]         old_word,
  input  logic [DATA_WIDTH-1:0]         old_victim,
  input  logic                          fault_en,
  input  logic [1:0]                    fault_type,
  input  logic [ADDR_WIDTH-1:0]         fault_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] fault_bit,
  output logic [DATA_WIDTH-1:0]         store_word,
  output logic [DATA_WIDTH-1:0]         victim_word,
  output logic                          victim_we,
  output logic [DATA_WIDTH-1:0]         read_word,
  output logic                          activated
);
  import fault_mem_pkg::*;

  logic [DATA_WIDTH-1:0] bmask;
  logic [ADDR_WIDTH-1:0] agg;
  logic                  hit_v;
  logic                  hit_a;
  logic                  forced;

  assign bmask  = DATA_WIDTH'(1) << fault_bit;
  assign agg    = ADDR_WIDTH'(aggressor_addr(32'(fault_addr), 32'(DEPTH)));
  assign hit_v  = fault_en && (address == fault_addr);
  // A write to the victim itself never couples, even if agg could alias it.
  assign hit_a  = fault_en && (address == agg) && (address != fault_addr);
  assign forced = (fault_type == FT_SAF1);

  always_comb begin
    store_word  = wdata;
    read_word   = old_word;
    victim_word = old_victim;
    victim_we   = 1'b0;
    activated   = 1'b0;
    case (fault_type)
      FT_SAF0, FT_SAF1: begin
        if (hit_v) begin
          if (is_write) begin
            store_word[fault_bit] = forced;
            activated             = (wdata[fault_bit] != forced);
          end else begin
            read_word[fault_bit] = forced;
            activated            = (old_word[fault_bit] != forced);
          end
        end
      end
      FT_TF_UP: begin
        if (hit_v && is_write && !old_word[fault_bit] && wdata[fault_bit]) begin
          store_word[fault_bit] = 1'b0;
          activated             = 1'b1;
        end
      end
      FT_CFIN: begin
        if (hit_a && is_write && !old_word[fault_bit] && wdata[fault_bit]) begin
          victim_word = old_victim ^ bmask;
          victim_we   = 1'b1;
          activated   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fault_mem_multi.sv
// Fault-injecting single-port memory model with run-time selectable faults.
// Ports: clk, rst (sync, active high); en/write_read/address/wdata request;
//        fault_en/fault_type/fault_addr/fault_bit fault configuration;
//        rdata/rvalid read response (2-cycle latency); fault_cnt saturating
//        count of fault activations.
// Requests are captured into a stage register, executed one edge later
// (write to array or read registered), and read data is presented the edge
// after that.
module fault_mem_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          write_read,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          fault_en,
  input  logic [1:0]                    fault_type,
  input  logic [ADDR_WIDTH-1:0]         fault_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] fault_bit,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rvalid,
  output logic [CNT_WIDTH-1:0]          fault_cnt
);
  import fault_mem_pkg::*;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  s_valid;
  logic                  s_write;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  rd_pend;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  in_range;
  logic                  v_ok;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] old_victim;
  logic [DATA_WIDTH-1:0] store_word;
  logic [DATA_WIDTH-1:0] victim_word;
  logic                  victim_we;
  logic [DATA_WIDTH-1:0] read_word;
  logic                  activated;
  logic                  wr_main;
  logic                  wr_victim;
  logic                  count_act;

  assign in_range   = ({1'b0, s_addr} < (ADDR_WIDTH+1)'(DEPTH));
  assign v_ok       = ({1'b0, fault_addr} < (ADDR_WIDTH+1)'(DEPTH));
  assign old_word   = in_range ? mem[s_addr] : '0;
  assign old_victim = v_ok ? mem[fault_addr] : '0;

  fault_mem_inject #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_inject (
    .is_write   (s_write),
    .address    (s_addr),
    .wdata      (s_wdata),
    .old_word   (old_word),
    .old_victim (old_victim),
    .fault_en   (fault_en),
    .fault_type (fault_type),
    .fault_addr (fault_addr),
    .fault_bit  (fault_bit),
    .store_word (store_word),
    .victim_word(victim_word),
    .victim_we  (victim_we),
    .read_word  (read_word),
    .activated  (activated)
  );

  assign wr_main   = s_valid && s_write && in_range;
  assign wr_victim = wr_main && victim_we && v_ok;
  // Out-of-range accesses never count, whatever the injector reports.
  assign count_act = s_valid && in_range && activated;

  // Array has no reset; rst only suppresses the in-flight write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_main)   mem[s_addr]     <= store_word;
      if (wr_victim) mem[fault_addr] <= victim_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid   <= 1'b0;
      s_write   <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      rd_pend   <= 1'b0;
      rd_word   <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      fault_cnt <= '0;
    end else begin
      s_valid <= en;
      s_write <= write_read;
      s_addr  <= address;
      s_wdata <= wdata;
      rd_pend <= s_valid && !s_write;
      rd_word <= (s_valid && !s_write && in_range) ? read_word : '0;
      rvalid  <= rd_pend;
      if (rd_pend) rdata <= rd_word;
      if (count_act && (fault_cnt != '1)) fault_cnt <= fault_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fault_mem_multi.sv
module tb_fault_mem_multi;

  logic       clk;
  logic       rst;
  logic       en_a, en_b;
  logic       wr;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       fault_en;
  logic [1:0] fault_type;
  logic [3:0] fault_addr;
  logic [2:0] fault_bit;
  logic [7:0] rdata_a, rdata_b;
  logic       rvalid_a, rvalid_b;
  logic [7:0] cnt_a, cnt_b;

  fault_mem_multi #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .write_read(wr), .address(addr), .wdata(wdata),
    .fault_en(fault_en), .fault_type(fault_type), .fault_addr(fault_addr), .fault_bit(fault_bit),
    .rdata(rdata_a), .rvalid(rvalid_a), .fault_cnt(cnt_a));

  fault_mem_multi #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .write_read(wr), .address(addr), .wdata(wdata),
    .fault_en(fault_en), .fault_type(fault_type), .fault_addr(fault_addr), .fault_bit(fault_bit),
    .rdata(rdata_b), .rvalid(rvalid_b), .fault_cnt(cnt_b));

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [7:0] cnt;
    int         edge_n;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per rvalid pulse; checks data, counter and latency.
  always @(negedge clk) begin
    if (rvalid_a === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid_a_unexpected actual=1 expected=0");
      end else begin
        ea = qa.pop_front();
        chk({ea.name, "_data"}, 32'(rdata_a), 32'(ea.data));
        chk({ea.name, "_cnt"},  32'(cnt_a),   32'(ea.cnt));
        chk({ea.name, "_lat"},  32'(edges),   32'(ea.edge_n));
      end
    end
    if (rvalid_b === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid_b_unexpected actual=1 expected=0");
      end else begin
        eb = qb.pop_front();
        chk({eb.name, "_data"}, 32'(rdata_b), 32'(eb.data));
        chk({eb.name, "_cnt"},  32'(cnt_b),   32'(eb.cnt));
        chk({eb.name, "_lat"},  32'(edges),   32'(eb.edge_n));
      end
    end
  end

  // All tasks are entered and left at a falling edge.
  task automatic idle(input int n);
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input bit sel_b, input logic [3:0] a, input logic [7:0] d);
    en_a = !sel_b; en_b = sel_b; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic do_read(input bit sel_b, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] c, input string name);
    exp_t e;
    en_a = !sel_b; en_b = sel_b; wr = 1'b0; addr = a; wdata = 8'h00;
    e.name = name; e.data = d; e.cnt = c; e.edge_n = edges + 1 + 2;
    if (sel_b) qb.push_back(e); else qa.push_back(e);
    @(negedge clk);
    idle(1);
  endtask

  task automatic pulse_reset();
    en_a = 1'b0; en_b = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    fault_en = 1'b0; fault_type = 2'd0; fault_addr = '0; fault_bit = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_rdata",  32'(rdata_a),  32'h0);
    chk("reset_rvalid", 32'(rvalid_a), 32'h0);
    chk("reset_cnt",    32'(cnt_a),    32'h0);

    // Ideal memory.
    do_write(0, 4'd3, 8'hA5);
    do_read (0, 4'd3, 8'hA5, 8'd0, "t1_ideal");
    idle(2);

    // SAF0 on word 5 bit 2.
    pulse_reset();
    fault_en = 1'b1; fault_type = 2'd0; fault_addr = 4'd5; fault_bit = 3'd2;
    do_write(0, 4'd5, 8'hFF);
    do_read (0, 4'd5, 8'hFB, 8'd1, "t2_saf0_ff");
    do_write(0, 4'd5, 8'h00);
    do_read (0, 4'd5, 8'h00, 8'd1, "t2_saf0_00");
    idle(2);

    // Transition-up fault on word 7 bit 0.
    pulse_reset();
    fault_type = 2'd2; fault_addr = 4'd7; fault_bit = 3'd0;
    do_write(0, 4'd7, 8'h00);
    do_write(0, 4'd7, 8'h01);
    do_read (0, 4'd7, 8'h00, 8'd1, "t3_tf_01");
    do_write(0, 4'd7, 8'h03);
    do_read (0, 4'd7, 8'h02, 8'd2, "t3_tf_03");
    idle(2);

    // Inversion coupling, victim 15 bit 5, aggressor wraps to 0.
    pulse_reset();
    fault_type = 2'd3; fault_addr = 4'd15; fault_bit = 3'd5;
    do_write(0, 4'd15, 8'h00);
    do_write(0, 4'd0,  8'h00);
    do_write(0, 4'd0,  8'h20);
    do_read (0, 4'd15, 8'h20, 8'd1, "t4_cfin_v");
    do_read (0, 4'd0,  8'h20, 8'd1, "t4_cfin_a");
    do_write(0, 4'd0,  8'h20);
    do_read (0, 4'd15, 8'h20, 8'd1, "t4_cfin_rep");
    idle(2);

    // Reset during an in-flight read: no rvalid, outputs cleared, array kept.
    en_a = 1'b1; wr = 1'b0; addr = 4'd15;
    @(negedge clk);
    en_a = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rst_rdata",  32'(rdata_a),  32'h0);
    chk("t5_rst_rvalid", 32'(rvalid_a), 32'h0);
    chk("t5_rst_cnt",    32'(cnt_a),    32'h0);
    do_read(0, 4'd15, 8'h20, 8'd0, "t5_array_kept");
    idle(2);

    // Out-of-range on the 12-word instance.
    fault_en = 1'b0;
    do_write(1, 4'd13, 8'h55);
    do_read (1, 4'd13, 8'h00, 8'd0, "t5_oob");
    do_write(1, 4'd11, 8'h5A);
    do_read (1, 4'd11, 8'h5A, 8'd0, "t5_top_word");
    idle(2);

    // Back-to-back write/read, then counter saturation under SAF1.
    pulse_reset();
    do_write(0, 4'd9, 8'h3C);
    do_read (0, 4'd9, 8'h3C, 8'd0, "t6_b2b");
    idle(2);
    fault_en = 1'b1; fault_type = 2'd1; fault_addr = 4'd9; fault_bit = 3'd7;
    for (int i = 0; i < 254; i++) do_write(0, 4'd9, 8'h00);
    do_read(0, 4'd9, 8'h80, 8'd254, "t6_cnt254");
    for (int i = 0; i < 6; i++) do_write(0, 4'd9, 8'h00);
    do_read(0, 4'd9, 8'h80, 8'd255, "t6_sat");
    idle(2);
    chk("t6_sat_hold", 32'(cnt_a), 32'd255);

    idle(4);
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
